// File: rtl/mem_stage.sv
`default_nettype none
// =============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory-access stage: data RAM, memory-mapped timer/LED/
//            systick block, write-back select and the MEM_WB register.
// Revision : 1.0
// =============================================================================
module mem_stage #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [72:0] EX_MEM,
    output logic        MEM_RegWrite,
    output logic [4:0]  MEM_WriteRegister,
    output logic [31:0] MEM_RegWriteData,
    output logic [37:0] MEM_WB,
    output logic        irq,
    output logic [7:0]  led
);

    localparam int          c_IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [31:0] c_ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] c_ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] c_ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] c_ADDR_LED  = 32'h4000_000C;
    localparam logic [31:0] c_ADDR_TICK = 32'h4000_0014;

    logic [31:0]        w_storeData;
    logic [31:0]        w_addr;
    logic [31:0]        w_wordAddr;
    logic [4:0]         w_dest;
    logic               w_memWrite;
    logic [1:0]         w_memtoReg;
    logic               w_regWrite;
    logic               w_isRam;
    logic [c_IDX_W-1:0] w_ramIdx;
    logic [31:0]        w_readData;
    logic [31:0]        w_wbData;
    logic               w_wrRam;
    logic               w_wrTh;
    logic               w_wrTl;
    logic               w_wrTcon;
    logic               w_wrLed;

    logic [31:0]        r_ram [RAM_WORDS];
    logic [31:0]        r_th;
    logic [31:0]        r_tl;
    logic [2:0]         r_tcon;
    logic [7:0]         r_led;
    logic [31:0]        r_systick;
    logic [37:0]        r_memWb;

    assign w_storeData = EX_MEM[31:0];
    assign w_addr      = EX_MEM[63:32];
    assign w_dest      = EX_MEM[68:64];
    assign w_memWrite  = EX_MEM[69];
    assign w_memtoReg  = EX_MEM[71:70];
    assign w_regWrite  = EX_MEM[72];

    // Word access only: the byte offset never takes part in decode.
    assign w_wordAddr = {w_addr[31:2], 2'b00};
    assign w_isRam    = (w_addr < c_RAM_BYTES);
    assign w_ramIdx   = w_addr[c_IDX_W+1:2];

    assign w_wrRam  = w_memWrite && w_isRam;
    assign w_wrTh   = w_memWrite && (w_wordAddr == c_ADDR_TH);
    assign w_wrTl   = w_memWrite && (w_wordAddr == c_ADDR_TL);
    assign w_wrTcon = w_memWrite && (w_wordAddr == c_ADDR_TCON);
    assign w_wrLed  = w_memWrite && (w_wordAddr == c_ADDR_LED);

    always_comb begin
        w_readData = '0;
        if (w_isRam) begin
            w_readData = r_ram[w_ramIdx];
        end else begin
            case (w_wordAddr)
                c_ADDR_TH:   w_readData = r_th;
                c_ADDR_TL:   w_readData = r_tl;
                c_ADDR_TCON: w_readData = {29'd0, r_tcon};
                c_ADDR_LED:  w_readData = {24'd0, r_led};
                c_ADDR_TICK: w_readData = r_systick;
                default:     w_readData = '0;
            endcase
        end
    end

    // Link values already arrive through the ALU result, so only 01 selects memory.
    assign w_wbData = (w_memtoReg == 2'b01) ? w_readData : w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // RAM contents survive reset; only a store in flight is dropped.
        end else if (w_wrRam) begin
            r_ram[w_ramIdx] <= w_storeData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_tcon    <= '0;
            r_led     <= '0;
            r_systick <= '0;
            r_memWb   <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
            r_memWb   <= {w_regWrite, w_dest, w_wbData};
            if (w_wrTh) begin
                r_th <= w_storeData;
            end
            if (w_wrLed) begin
                r_led <= w_storeData[7:0];
            end
            if (w_wrTl) begin
                r_tl <= w_storeData;
            end else if (r_tcon[0]) begin
                if (r_tl == 32'hFFFF_FFFF) begin
                    r_tl <= r_th;
                    if (r_tcon[1]) begin
                        r_tcon[2] <= 1'b1;
                    end
                end else begin
                    r_tl <= r_tl + 32'd1;
                end
            end
            // Placed last so a software write overrides a same-edge status set.
            if (w_wrTcon) begin
                r_tcon <= w_storeData[2:0];
            end
        end
    end

    assign MEM_RegWrite      = w_regWrite;
    assign MEM_WriteRegister = w_dest;
    assign MEM_RegWriteData  = w_wbData;
    assign MEM_WB            = r_memWb;
    assign irq               = r_tcon[2] & r_tcon[1];
    assign led               = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage: directed scenarios plus random
//            traffic compared every cycle against a behavioural model.
// Revision : 1.0
// =============================================================================
module tb_mem_stage;

    localparam int          RAM_WORDS = 256;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [72:0] EX_MEM;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_WriteRegister;
    logic [31:0] MEM_RegWriteData;
    logic [37:0] MEM_WB;
    logic        irq;
    logic [7:0]  led;

    mem_stage #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .EX_MEM            (EX_MEM),
        .MEM_RegWrite      (MEM_RegWrite),
        .MEM_WriteRegister (MEM_WriteRegister),
        .MEM_RegWriteData  (MEM_RegWriteData),
        .MEM_WB            (MEM_WB),
        .irq               (irq),
        .led               (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit tbCheck  = 1'b0;

    // Behavioural model state
    logic [31:0] m_ram   [RAM_WORDS];
    bit          m_ramOk [RAM_WORDS];
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [37:0] m_wb;
    bit          m_wbOk;
    logic [31:0] exWord;

    assign exWord = {EX_MEM[63:34], 2'b00};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [72:0] mkEx(bit rw, logic [1:0] mtr, bit mw, logic [4:0] rd,
                                         logic [31:0] addr, logic [31:0] data);
        return {rw, mtr, mw, rd, addr, data};
    endfunction

    function automatic logic [72:0] mkLoad(logic [31:0] addr, logic [4:0] rd);
        return mkEx(1'b1, 2'b01, 1'b0, rd, addr, 32'd0);
    endfunction

    function automatic logic [72:0] mkStore(logic [31:0] addr, logic [31:0] data);
        return mkEx(1'b0, 2'b00, 1'b1, 5'd0, addr, data);
    endfunction

    function automatic logic [31:0] readData(logic [31:0] addr);
        logic [31:0] wa = {addr[31:2], 2'b00};
        if (addr < RAM_BYTES) return m_ram[addr[9:2]];
        if (wa == A_TH)   return m_th;
        if (wa == A_TL)   return m_tl;
        if (wa == A_TCON) return {29'd0, m_tcon};
        if (wa == A_LED)  return {24'd0, m_led};
        if (wa == A_TICK) return m_tick;
        return 32'd0;
    endfunction

    function automatic bit readKnown(logic [31:0] addr);
        if (addr < RAM_BYTES) return m_ramOk[addr[9:2]];
        return 1'b1;
    endfunction

    function automatic logic [31:0] wbData(logic [72:0] ex);
        return (ex[71:70] == 2'b01) ? readData(ex[63:32]) : ex[63:32];
    endfunction

    function automatic bit wbKnown(logic [72:0] ex);
        return (ex[71:70] != 2'b01) || readKnown(ex[63:32]);
    endfunction

    // Model advances on the same edges as the DUT, from pre-edge model values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_th   <= '0;
            m_tl   <= '0;
            m_tcon <= '0;
            m_led  <= '0;
            m_tick <= '0;
            m_wb   <= '0;
            m_wbOk <= 1'b1;
        end else begin
            m_tick <= m_tick + 1;
            m_wb   <= {EX_MEM[72], EX_MEM[68:64], wbData(EX_MEM)};
            m_wbOk <= wbKnown(EX_MEM);
            if (EX_MEM[69] && EX_MEM[63:32] < RAM_BYTES) begin
                m_ram[EX_MEM[41:34]]   <= EX_MEM[31:0];
                m_ramOk[EX_MEM[41:34]] <= 1'b1;
            end
            if (EX_MEM[69] && exWord == A_TH)  m_th  <= EX_MEM[31:0];
            if (EX_MEM[69] && exWord == A_LED) m_led <= EX_MEM[7:0];
            if (EX_MEM[69] && exWord == A_TL) begin
                m_tl <= EX_MEM[31:0];
            end else if (m_tcon[0]) begin
                m_tl <= (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
                if (m_tl == 32'hFFFF_FFFF && m_tcon[1]) m_tcon[2] <= 1'b1;
            end
            if (EX_MEM[69] && exWord == A_TCON) m_tcon <= EX_MEM[2:0];
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        if (tbCheck) begin
            if (!rst_n) begin
                chk("rst_memwb", 64'(MEM_WB), 64'd0);
                chk("rst_led", 64'(led), 64'd0);
                chk("rst_irq", 64'(irq), 64'd0);
            end else begin
                chk("fwd_regwrite", 64'(MEM_RegWrite), 64'(EX_MEM[72]));
                chk("fwd_dest", 64'(MEM_WriteRegister), 64'(EX_MEM[68:64]));
                if (wbKnown(EX_MEM)) chk("fwd_data", 64'(MEM_RegWriteData), 64'(wbData(EX_MEM)));
                if (m_wbOk) chk("mem_wb", 64'(MEM_WB), 64'(m_wb));
                chk("irq", 64'(irq), 64'(m_tcon[2] & m_tcon[1]));
                chk("led", 64'(led), 64'(m_led));
            end
        end
    end

    // Drive one EX_MEM value just after a rising edge; returns at edge+3.
    task automatic step(input logic [72:0] ex);
        @(posedge clk);
        #1;
        EX_MEM = ex;
        #2;
    endtask

    function automatic logic [72:0] randEx();
        logic [31:0] addr;
        logic [31:0] data;
        int sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: addr = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
            4:          addr = A_TH;
            5:          addr = A_TL;
            6:          addr = A_TCON;
            7:          addr = A_LED;
            8:          addr = ($urandom_range(0, 1) != 0) ? A_TICK : 32'h4000_0010;
            default:    addr = $urandom;
        endcase
        if (sel >= 4 && sel <= 8) addr[1:0] = 2'($urandom_range(0, 3));
        data = $urandom;
        if ((sel == 4 || sel == 5) && $urandom_range(0, 1) != 0)
            data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return mkEx(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), addr, data);
    endfunction

    initial begin
        EX_MEM = '0;
        rst_n  = 1'b1;
        #1;
        rst_n   = 1'b0;
        tbCheck = 1'b1;

        // Reset with bubble held for three cycles
        repeat (3) @(posedge clk);
        #3;
        chk("reset_memwb", 64'(MEM_WB), 64'd0);
        chk("reset_led", 64'(led), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        EX_MEM = mkLoad(A_TICK, 5'd1);
        #2;
        chk("tick_0", 64'(MEM_RegWriteData), 64'd0);
        step(mkLoad(A_TICK, 5'd1));
        chk("tick_1", 64'(MEM_RegWriteData), 64'd1);
        step(mkLoad(A_TICK, 5'd1));
        chk("tick_2", 64'(MEM_RegWriteData), 64'd2);

        // Store then load with byte offset
        step(mkStore(32'h10, 32'hDEAD_BEEF));
        step(mkLoad(32'h13, 5'd5));
        chk("load_fwd", 64'(MEM_RegWriteData), 64'hDEAD_BEEF);
        step(mkEx(1'b1, 2'b00, 1'b0, 5'd8, 32'h1234, 32'd0));
        chk("load_memwb", 64'(MEM_WB), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
        chk("alu_regwrite", 64'(MEM_RegWrite), 64'd1);
        chk("alu_dest", 64'(MEM_WriteRegister), 64'd8);
        chk("alu_data", 64'(MEM_RegWriteData), 64'h1234);
        step('0);
        chk("alu_memwb", 64'(MEM_WB[31:0]), 64'h1234);
        chk("bubble_regwrite", 64'(MEM_RegWrite), 64'd0);
        step('0);
        chk("bubble_memwb_rw", 64'(MEM_WB[37]), 64'd0);

        // Timer wrap and interrupt
        step(mkStore(A_TH, 32'hFFFF_FFFD));
        step(mkStore(A_TL, 32'hFFFF_FFFE));
        step(mkStore(A_TCON, 32'd3));
        step(mkLoad(A_TL, 5'd2));
        chk("tl_before_count", 64'(MEM_RegWriteData), 64'hFFFF_FFFE);
        step(mkLoad(A_TL, 5'd2));
        chk("tl_first_count", 64'(MEM_RegWriteData), 64'hFFFF_FFFF);
        chk("irq_before_wrap", 64'(irq), 64'd0);
        step(mkLoad(A_TL, 5'd2));
        chk("tl_reload", 64'(MEM_RegWriteData), 64'hFFFF_FFFD);
        chk("irq_after_wrap", 64'(irq), 64'd1);
        step(mkLoad(A_TCON, 5'd2));
        chk("tcon_status", 64'(MEM_RegWriteData), 64'd7);
        chk("pin_model_tcon", 64'(m_tcon), 64'd7);
        step(mkStore(A_TCON, 32'd3));
        step('0);
        chk("irq_cleared", 64'(irq), 64'd0);

        // LED width, unmapped region
        step(mkStore(A_LED, 32'h1A5));
        step(mkLoad(A_LED, 5'd3));
        chk("led_out", 64'(led), 64'hA5);
        chk("led_read", 64'(MEM_RegWriteData), 64'hA5);
        step(mkStore(32'h5000_0000, 32'hFFFF_FFFF));
        step(mkLoad(32'h5000_0000, 5'd3));
        chk("unmapped_read", 64'(MEM_RegWriteData), 64'd0);

        // Mid-cycle reset with a store in flight and the timer running
        step(mkStore(32'h20, 32'h1111_2222));
        step(mkStore(32'h20, 32'h0000_0099));
        rst_n = 1'b0;
        #1;
        chk("midrst_memwb", 64'(MEM_WB), 64'd0);
        chk("midrst_led", 64'(led), 64'd0);
        chk("midrst_irq", 64'(irq), 64'd0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        EX_MEM = mkLoad(32'h20, 5'd4);
        #2;
        chk("dropped_store", 64'(MEM_RegWriteData), 64'h1111_2222);
        step(mkLoad(A_TL, 5'd4));
        chk("midrst_tl", 64'(MEM_RegWriteData), 64'd0);
        step(mkLoad(A_TCON, 5'd4));
        chk("midrst_tcon", 64'(MEM_RegWriteData), 64'd0);

        // Random traffic; occasional mid-cycle reset pulses
        for (int i = 0; i < 3000; i++) begin
            step(randEx());
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n  = 1'b1;
                EX_MEM = randEx();
                #2;
            end
        end

        step('0);
        @(posedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the 73-bit EX_MEM bus, performs load/store accesses to a word-addressed data RAM and a small memory-mapped peripheral block (timer, LEDs, system tick), and selects the write-back value. It registers the result into the MEM_WB bus and drives the MEM-side forwarding signals back to execute.

## Interface
Parameters:
- RAM_WORDS, 256: data RAM depth in 32-bit words; byte range 0x0 to 4*RAM_WORDS-1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- EX_MEM  input  73  from execute:
  - [31:0] store data.
  - [63:32] ALU result, used as address and non-load write-back value.
  - [68:64] destination register.
  - [69] MemWrite.
  - [71:70] MemtoReg.
  - [72] RegWrite.
- MEM_RegWrite  output  1  EX_MEM[72], combinational; forwarding to execute.
- MEM_WriteRegister  output  5  EX_MEM[68:64], combinational.
- MEM_RegWriteData  output  32  selected write-back value, combinational; includes load data.
- MEM_WB  output  38  registered:
  - [31:0] write-back data.
  - [36:32] destination register.
  - [37] RegWrite.
- irq  output  1  timer interrupt request.
- led  output  8  LED register.

## Operation
- Address decode uses addr = EX_MEM[63:32]; addr[1:0] is ignored (word access only).
- RAM: addr < 4*RAM_WORDS, word index addr[31:2].
- 0x4000_0000 TH: timer reload, R/W.
- 0x4000_0004 TL: timer count, R/W.
- 0x4000_0008 TCON: bits [2:0], R/W, upper bits read 0.
  - bit0: enable.
  - bit1: irq enable.
  - bit2: irq status.
- 0x4000_000C LED: bits [7:0], R/W.
- 0x4000_0014 SYSTICK: read-only, free-running counter.
- Any other address: reads return 0; writes are ignored.
- Read data is combinational from the current EX_MEM address (asynchronous RAM read).
- Write-back select:
  - MemtoReg == 01: read data.
  - 00, 10, 11: ALU result. Link values are already produced by execute through the ALU.
- Store: when EX_MEM[69]=1, the addressed location takes EX_MEM[31:0] at the rising edge.
- Timer, evaluated each edge using pre-edge values:
  - A write to TL takes priority over counting.
  - Otherwise, if TCON[0]=1: if TL==0xFFFF_FFFF, TL<=TH and TCON[2]<=1 when TCON[1]=1; else TL<=TL+1.
- A write to TCON replaces all three bits, overriding a same-edge status set. This is how software clears the interrupt.
- irq = TCON[2] & TCON[1], combinational from the registers.
- SYSTICK increments by 1 every edge and wraps from 0xFFFF_FFFF to 0.
- MEM_WB is written every edge from the current selection; the stage never stalls.
- EX_MEM bubbles (all zero) produce MEM_WB RegWrite=0.

## Timing
- Reset (asynchronous assert, any cycle, including mid-store):
  - Cleared to 0: MEM_WB, TH, TL, TCON, LED, SYSTICK, so irq=0 and led=0.
  - A store in flight at reset is dropped.
  - RAM contents are not reset and are undefined until written.
- Load latency: data appears on MEM_RegWriteData in the same cycle the load is in EX_MEM. It is on MEM_WB one edge later.
- Store-to-load: a store at edge k is visible to a load present in EX_MEM after edge k. There is no same-cycle store/load conflict, since only one access exists per cycle.
- A TCON write enabling the timer at edge k gives the first count at edge k+1.
- irq rises in the cycle after the wrap edge.
- MEM forwarding outputs change combinationally with EX_MEM. They carry no extra register stage.

## Test plan
- Reset with EX_MEM=0, hold 3 cycles -> MEM_WB=0, led=0, irq=0; SYSTICK read returns 0 in the first cycle after rst_n rises, then 1, 2.
- Store 0xDEADBEEF to 0x10, then the next cycle load 0x13 (MemtoReg=01, reg 5, RegWrite=1) -> MEM_RegWriteData=0xDEADBEEF combinationally; MEM_WB={1, 5'd5, 0xDEADBEEF} after the edge.
- ALU op, RegWrite=1, reg 8, result 0x1234, MemtoReg=00 -> MEM_RegWrite=1, MEM_WriteRegister=8, MEM_RegWriteData=0x1234; MEM_WB[31:0]=0x1234 next edge.
- Write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3 on successive edges:
  - -> TL=0xFFFF_FFFF after one edge, then TL=0xFFFF_FFFD with TCON=7 and irq=1.
  - Write TCON=3 -> irq=0.
- Write LED=0x1A5 -> led=0xA5; read LED returns 0xA5. Store to 0x5000_0000 -> no state change; load from it returns 0.
- Assert rst_n low mid-cycle while a store to 0x20 is in EX_MEM and the timer is running -> TL, TCON, MEM_WB and led clear immediately; after release a load of 0x20 returns the previously written value, unaffected by the dropped store.
